// File: rtl/line_raster_engine_pkg.sv
// Shared graphics definitions for the line rasteriser: FSM encoding,
// default framebuffer geometry and the colour type.
package line_raster_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FB_W_DEF    = 640;
    localparam int FB_H_DEF    = 480;
    localparam int ADDR_W_DEF  = 19;
    localparam int COLOR_W_DEF = 3;

    typedef logic [COLOR_W_DEF-1:0] color_t;

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham advance along the major axis: next x, y and error term.
module bresenham_step #(
    parameter int COORD_W = 13
) (
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic signed [COORD_W:0]   err,
    input  logic [COORD_W-1:0]        dx,
    input  logic [COORD_W-1:0]        dy,
    input  logic                      ystep_neg,
    output logic [COORD_W-1:0]        next_x,
    output logic [COORD_W-1:0]        next_y,
    output logic signed [COORD_W:0]   next_err
);

    logic signed [COORD_W:0] err_dec;

    // err stays in [0, dx] and err_dec in [-dy, dx], so COORD_W+1 signed bits suffice
    always_comb begin
        next_x   = x + COORD_W'(1);
        err_dec  = err - $signed({1'b0, dy});
        next_y   = y;
        next_err = err_dec;
        if (err_dec < 0) begin
            next_y   = ystep_neg ? (y - COORD_W'(1)) : (y + COORD_W'(1));
            next_err = err_dec + $signed({1'b0, dx});
        end
    end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser emitting one pixel per cycle over a valid/ready stream.
// Define LINE_RASTER_CLIP_EN to drop pixels outside the FB_W x FB_H framebuffer.
module line_raster_engine
    import line_raster_engine_pkg::*;
#(
    parameter int COORD_W = 13,
    parameter int FB_W    = FB_W_DEF,
    parameter int FB_H    = FB_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done
);

    localparam logic [31:0]       FB_W_L = FB_W;
    localparam logic [31:0]       FB_H_L = FB_H;
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    state_t state, state_next;

    logic [COORD_W-1:0] cx0, cy0, cx1, cy1;
    logic [COLOR_W-1:0] color_r;
    logic [COORD_W-1:0] x, y, x_end, dx, dy;
    logic signed [COORD_W:0] err;
    logic               steep, ystep_neg;

    logic [COORD_W-1:0] adx, ady, sx0, sy0, sx1, sy1, ex0, ey0, ex1, ey1;
    logic               s_steep, s_swap;
    logic [COORD_W-1:0] nx, ny;
    logic signed [COORD_W:0] nerr;
    logic               in_fb, clip, advance, last;

    // Setup: fold every octant into a left-to-right, shallow line
    always_comb begin
        adx     = (cx1 >= cx0) ? (cx1 - cx0) : (cx0 - cx1);
        ady     = (cy1 >= cy0) ? (cy1 - cy0) : (cy0 - cy1);
        s_steep = ady > adx;
        sx0     = s_steep ? cy0 : cx0;
        sy0     = s_steep ? cx0 : cy0;
        sx1     = s_steep ? cy1 : cx1;
        sy1     = s_steep ? cx1 : cy1;
        s_swap  = sx0 > sx1;
        ex0     = s_swap ? sx1 : sx0;
        ey0     = s_swap ? sy1 : sy0;
        ex1     = s_swap ? sx0 : sx1;
        ey1     = s_swap ? sy0 : sy1;
    end

    bresenham_step #(.COORD_W(COORD_W)) u_step (
        .x         (x),
        .y         (y),
        .err       (err),
        .dx        (dx),
        .dy        (dy),
        .ystep_neg (ystep_neg),
        .next_x    (nx),
        .next_y    (ny),
        .next_err  (nerr)
    );

    assign pix_x     = steep ? y : x;
    assign pix_y     = steep ? x : y;
    assign pix_color = color_r;
    assign pix_addr  = ADDR_W'(pix_y) * FB_W_A + ADDR_W'(pix_x);
    assign in_fb     = (32'(pix_x) < FB_W_L) && (32'(pix_y) < FB_H_L);

`ifdef LINE_RASTER_CLIP_EN
    assign clip = (state == DRAW) && !in_fb;
`else
    logic unused_in_fb;
    assign unused_in_fb = in_fb;
    assign clip         = 1'b0;
`endif

    assign advance = (pix_valid && pix_ready) || clip;
    assign last    = x == x_end;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = DRAW;
            DRAW:    if (advance && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        done      = state == DONE;
        pix_valid = (state == DRAW) && !clip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx0 <= '0; cy0 <= '0; cx1 <= '0; cy1 <= '0;
            color_r   <= '0;
            x         <= '0;
            y         <= '0;
            x_end     <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            steep     <= 1'b0;
            ystep_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cx0 <= x0; cy0 <= y0; cx1 <= x1; cy1 <= y1;
                    color_r <= color;
                end
                SETUP: begin
                    steep     <= s_steep;
                    x         <= ex0;
                    y         <= ey0;
                    x_end     <= ex1;
                    dx        <= ex1 - ex0;
                    dy        <= (ey1 >= ey0) ? (ey1 - ey0) : (ey0 - ey1);
                    ystep_neg <= !(ey0 < ey1);
                    err       <= $signed({2'b00, (ex1 - ex0) >> 1});
                end
                DRAW: if (advance && !last) begin
                    x   <= nx;
                    y   <= ny;
                    err <= nerr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed self-checking bench for line_raster_engine; expectations follow
// LINE_RASTER_CLIP_EN when it is defined for the build.
module tb_line_raster_engine;
    import line_raster_engine_pkg::*;

    localparam int CW = 13;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    color_t        color = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [CW-1:0] pix_x, pix_y;
    logic [AW-1:0] pix_addr;
    color_t        pix_color;
    logic          busy, done;

    line_raster_engine dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr), .pix_color(pix_color),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int acc_x[$], acc_y[$], acc_a[$], acc_c[$];
    int first_cyc, last_cyc, done_cyc;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic send_cmd(input int a, input int b, input int c, input int d, input int col);
        int w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_before_send", int'(cmd_ready), 1);
        x0 = CW'(a); y0 = CW'(b); x1 = CW'(c); y1 = CW'(d);
        color = color_t'(col);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_line(input bit toggle, input bit garbage, input int budget);
        logic [CW-1:0] sx, sy;
        logic [AW-1:0] sa;
        bit stalled = 1'b0;
        acc_x.delete(); acc_y.delete(); acc_a.delete(); acc_c.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            pix_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (garbage) begin
                cmd_valid = 1'b1; x0 = 9; y0 = 1; x1 = 1; y1 = 9;
            end
            #1;
            if (stalled && pix_valid) begin
                check("stall_hold_x", int'(pix_x), int'(sx));
                check("stall_hold_y", int'(pix_y), int'(sy));
                check("stall_hold_addr", int'(pix_addr), int'(sa));
            end
            stalled = 1'b0;
            if (pix_valid && first_cyc < 0) first_cyc = cyc;
            if (pix_valid && pix_ready) begin
                acc_x.push_back(int'(pix_x));
                acc_y.push_back(int'(pix_y));
                acc_a.push_back(int'(pix_addr));
                acc_c.push_back(int'(pix_color));
                last_cyc = cyc;
            end else if (pix_valid) begin
                stalled = 1'b1;
                sx = pix_x; sy = pix_y; sa = pix_addr;
            end
            if (done) begin
                done_cyc = cyc;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("done_seen", int'(done_cyc >= 0), 1);
        @(negedge clk);
        check("ready_after_done", int'(cmd_ready), 1);
        check("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int steep_x[8] = '{0, 0, 1, 1, 1, 1, 2, 2};
        int seen;
        int bad;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pix_x", int'(pix_x), 0);
        check("rst_pix_y", int'(pix_y), 0);
        check("rst_pix_addr", int'(pix_addr), 0);
        check("rst_pix_color", int'(pix_color), 0);
        rst = 1'b0;
        @(negedge clk);

        // Horizontal line
        send_cmd(0, 0, 4, 0, 3);
        check("horiz_busy", int'(busy), 1);
        run_line(1'b0, 1'b0, 40);
        check("horiz_count", acc_x.size(), 5);
        for (int i = 0; i < acc_x.size() && i < 5; i++) begin
            check($sformatf("horiz_x%0d", i), acc_x[i], i);
            check($sformatf("horiz_y%0d", i), acc_y[i], 0);
            check($sformatf("horiz_addr%0d", i), acc_a[i], i);
        end
        check("horiz_color", (acc_c.size() > 0) ? acc_c[0] : -1, 3);
        check("horiz_first_latency", first_cyc, 1);
        check("horiz_done_after_last", done_cyc, last_cyc + 1);

        // Steep reversed line
        send_cmd(2, 7, 0, 0, 6);
        run_line(1'b0, 1'b0, 40);
        check("steep_count", acc_x.size(), 8);
        for (int i = 0; i < acc_x.size() && i < 8; i++) begin
            check($sformatf("steep_x%0d", i), acc_x[i], steep_x[i]);
            check($sformatf("steep_y%0d", i), acc_y[i], i);
            check($sformatf("steep_addr%0d", i), acc_a[i], i * 640 + steep_x[i]);
        end
        check("steep_color", (acc_c.size() > 0) ? acc_c[0] : -1, 6);

        // Diagonal with 1010 backpressure and a stray command while busy
        send_cmd(0, 0, 3, 3, 1);
        run_line(1'b1, 1'b1, 40);
        check("bp_count", acc_x.size(), 4);
        for (int i = 0; i < acc_x.size() && i < 4; i++) begin
            check($sformatf("bp_x%0d", i), acc_x[i], i);
            check($sformatf("bp_y%0d", i), acc_y[i], i);
            check($sformatf("bp_addr%0d", i), acc_a[i], i * 641);
        end
        check("bp_color", (acc_c.size() > 0) ? acc_c[3] : -1, 1);
        check("bp_done_cycle", done_cyc, 9);

        // Reset on the third pixel of a long line
        send_cmd(0, 0, 10, 0, 2);
        pix_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (pix_valid) seen++;
            if (seen == 3) break;
            @(negedge clk);
        end
        check("rst_mid_third_x", int'(pix_x), 2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_pix_valid", int'(pix_valid), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_cmd_ready", int'(cmd_ready), 1);
        check("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done || pix_valid) bad++;
        end
        check("rst_mid_quiet", bad, 0);

        // Degenerate line right after the reset
        send_cmd(5, 5, 5, 5, 7);
        run_line(1'b0, 1'b0, 40);
        check("degen_count", acc_x.size(), 1);
        check("degen_x", (acc_x.size() > 0) ? acc_x[0] : -1, 5);
        check("degen_y", (acc_y.size() > 0) ? acc_y[0] : -1, 5);
        check("degen_addr", (acc_a.size() > 0) ? acc_a[0] : -1, 3205);
        check("degen_done_cycle", done_cyc, 2);

        // Line crossing the right framebuffer edge
        send_cmd(636, 0, 643, 0, 4);
        run_line(1'b0, 1'b0, 60);
`ifdef LINE_RASTER_CLIP_EN
        check("edge_count", acc_x.size(), 4);
`else
        check("edge_count", acc_x.size(), 8);
`endif
        for (int i = 0; i < acc_x.size(); i++) begin
            check($sformatf("edge_x%0d", i), acc_x[i], 636 + i);
            check($sformatf("edge_addr%0d", i), acc_a[i], 636 + i);
        end
        check("edge_done_cycle", done_cyc, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
